multiplier: RTL and testbench
=============================

# multiplier

Iterative 32×32→64-bit shift-add multiplier for the execute stage; the multiplicative counterpart of the core's iterative divider, sharing its start/busy handshake. It serves MUL, MULH, MULHSU and MULHU: the core selects the low or high product word. Per-operand signedness flags cover all four operand-sign combinations. One partial-product bit is retired per cycle, so the datapath is small at the cost of a fixed multi-cycle latency.

## Interface
Parameters: none (width fixed at 32).

- clock  in  1  core clock; all state updates on falling edge
- reset  in  1  asynchronous, active-high
- start  in  1  request; sampled only while busy=0
- a_signed  in  1  treat a as two's complement
- b_signed  in  1  treat b as two's complement
- a  in  32  multiplicand
- b  in  32  multiplier
- result_low  out  32  product bits [31:0]
- result_high  out  32  product bits [63:32]
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when result is final

## Operation
- States: IDLE, RUN, FINISH.
- IDLE, start=1:
  - Magnitudes: mag_a = (a_signed && a[31]) ? -a : a; likewise mag_b.
  - Both magnitudes are 32-bit unsigned, so 0x80000000 maps to 2^31.
  - sign = (a_signed && a[31]) ^ (b_signed && b[31]).
  - Clear the 64-bit accumulator and count; busy←1; go to RUN.
- RUN, one step per edge:
  - If mag_b[0], acc += mag_a (64-bit, zero-extended).
  - Then mag_a <<= 1 (64-bit), mag_b >>= 1, count++.
  - Go to FINISH after the step with count==31.
- FINISH:
  - If sign is negative, acc ← -acc (64-bit two's complement); otherwise unchanged.
  - busy←0; done←1 for this cycle only; go to IDLE.
- Outputs:
  - result_low and result_high are driven from acc.
  - They hold their value in IDLE until the next accepted start.
- Ignored starts: start while busy=1 is ignored, including on the FINISH edge. Operands are latched only at accept.
- Inputs a, b and the signedness flags may change freely after accept.
- Zero operands take the full latency; there is no early-out.

## Timing
- Reset (asynchronous):
  - state=IDLE, busy=0, done=0, result_low=0, result_high=0, count=0.
  - Reset mid-operation aborts immediately; no result is produced.
- Latency: accept edge, then 32 RUN edges, then 1 FINISH edge.
  - busy is high for 33 falling edges.
  - done and the final result appear on the 34th edge after start is sampled.
- Back-to-back: the earliest next accept is the edge after done, when busy=0.
- Intermediate accumulator values are visible on the result outputs during RUN; consumers must wait for busy to fall or for done.

## Structure
- Shared defines header holds SIGN_POSITIVE/SIGN_NEGATIVE, already used by the divider, plus the state encodings MUL_IDLE, MUL_RUN, MUL_FINISH.
- No sub-module: a single module with a 64-bit accumulator, a 64-bit shifted multiplicand, a 32-bit multiplier register and a 5-bit count.

## Test plan
- a=7, b=6, both flags 0 → after 34 edges: low=0x0000002A, high=0; done pulses once.
- a=-3, b=5, both signed → low=0xFFFFFFF1, high=0xFFFFFFFF.
- a=b=0xFFFFFFFF, unsigned (MULHU) → high=0xFFFFFFFE, low=0x00000001.
- a=0xFFFFFFFF with a_signed=1, b=2 with b_signed=0 (MULHSU) → high=0xFFFFFFFF, low=0xFFFFFFFE.
- a=b=0x80000000, both signed → high=0x40000000, low=0.
- Hazard sequence: start with 3×4; pulse start with 9×9 at edge 10; assert reset at edge 20; release; start 2×5.
  - The 9×9 request is ignored.
  - Reset clears outputs to 0 and busy to 0, with no done pulse.
  - The final result is low=10.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared encodings for the iterative execute-stage arithmetic units.
// Sign codes are common with the divider; state codes belong to the multiplier FSM.
package multiplier_pkg;

    localparam logic SIGN_POSITIVE = 1'b0;
    localparam logic SIGN_NEGATIVE = 1'b1;

    typedef enum logic [1:0] {
        MUL_IDLE   = 2'd0,
        MUL_RUN    = 2'd1,
        MUL_FINISH = 2'd2
    } mul_state_e;

    // 0x80000000 maps to 2^31, which still fits the 32-bit unsigned result.
    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
        return (is_signed && value[31]) ? (32'd0 - value) : value;
    endfunction

endpackage

// File: rtl/multiplier.sv
// Iterative 32x32->64 shift-add multiplier retiring one multiplier bit per falling edge.
// Serves MUL/MULH/MULHSU/MULHU through per-operand signedness flags.
module multiplier
    import multiplier_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        a_signed,
    input  logic        b_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result_low,
    output logic [31:0] result_high,
    output logic        busy,
    output logic        done
);

    mul_state_e  state_r, state_s;
    logic [63:0] acc_r, acc_s;
    logic [63:0] mcand_r, mcand_s;
    logic [31:0] mplier_r, mplier_s;
    logic [4:0]  count_r, count_s;
    logic        sign_r, sign_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;

    // Next-state and datapath update for the accept / run / finish sequence.
    always_comb begin
        state_s  = state_r;
        acc_s    = acc_r;
        mcand_s  = mcand_r;
        mplier_s = mplier_r;
        count_s  = count_r;
        sign_s   = sign_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        case (state_r)
            MUL_IDLE: begin
                if (start) begin
                    mcand_s  = {32'd0, magnitude(a, a_signed)};
                    mplier_s = magnitude(b, b_signed);
                    sign_s   = ((a_signed && a[31]) ^ (b_signed && b[31])) ? SIGN_NEGATIVE
                                                                          : SIGN_POSITIVE;
                    acc_s    = 64'd0;
                    count_s  = 5'd0;
                    busy_s   = 1'b1;
                    state_s  = MUL_RUN;
                end else begin
                    state_s  = MUL_IDLE;
                end
            end
            MUL_RUN: begin
                if (mplier_r[0]) begin
                    acc_s = acc_r + mcand_r;
                end else begin
                    acc_s = acc_r;
                end
                mcand_s  = mcand_r << 1;
                mplier_s = mplier_r >> 1;
                count_s  = count_r + 5'd1;
                if (count_r == 5'd31) begin
                    state_s = MUL_FINISH;
                end else begin
                    state_s = MUL_RUN;
                end
            end
            MUL_FINISH: begin
                if (sign_r == SIGN_NEGATIVE) begin
                    acc_s = 64'd0 - acc_r;
                end else begin
                    acc_s = acc_r;
                end
                busy_s  = 1'b0;
                done_s  = 1'b1;
                state_s = MUL_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = MUL_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight without producing a result.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= MUL_IDLE;
            acc_r    <= 64'd0;
            mcand_r  <= 64'd0;
            mplier_r <= 32'd0;
            count_r  <= 5'd0;
            sign_r   <= SIGN_POSITIVE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            acc_r    <= acc_s;
            mcand_r  <= mcand_s;
            mplier_r <= mplier_s;
            count_r  <= count_s;
            sign_r   <= sign_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    // Partial sums are visible while running; consumers qualify with busy/done.
    assign result_low  = acc_r[31:0];
    assign result_high = acc_r[63:32];
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_multiplier.sv
// Directed self-checking bench for the iterative multiplier: products, latency,
// done pulse, ignored starts and asynchronous reset abort.
module tb_multiplier;

    logic        clock;
    logic        reset;
    logic        start;
    logic        a_signed;
    logic        b_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result_low;
    logic [31:0] result_high;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    multiplier dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .a_signed    (a_signed),
        .b_signed    (b_signed),
        .a           (a),
        .b           (b),
        .result_low  (result_low),
        .result_high (result_high),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full operation; optionally re-asserts start on the FINISH edge, which must be ignored.
    task automatic do_mul(input string tag, input logic [31:0] a_v, input logic [31:0] b_v,
                          input logic as_v, input logic bs_v, input logic [63:0] exp,
                          input logic poke_finish);
        int n;
        @(posedge clock);
        a = a_v; b = b_v; a_signed = as_v; b_signed = bs_v; start = 1'b1;
        @(negedge clock); #1;
        check({tag, "_busy_accept"}, {63'd0, busy}, 64'd1);
        start = 1'b0;
        a = $urandom; b = $urandom; a_signed = ~as_v; b_signed = ~bs_v;
        n = 1;
        while (!done && n < 40) begin
            if (poke_finish && n == 33) begin
                start = 1'b1; a = 32'd9; b = 32'd9;
            end
            @(negedge clock); #1;
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'd34);
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_product"}, {result_high, result_low}, exp);
        @(negedge clock); #1;
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check({tag, "_idle"}, {63'd0, busy}, 64'd0);
        check({tag, "_hold"}, {result_high, result_low}, exp);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a_signed = 1'b0; b_signed = 1'b0; a = 32'd0; b = 32'd0;
        #12;
        check("reset_low", {32'd0, result_low}, 64'd0);
        check("reset_high", {32'd0, result_high}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        @(posedge clock);
        reset = 1'b0;

        do_mul("mul_7x6",     32'd7,          32'd6,          1'b0, 1'b0, 64'h0000_0000_0000_002A, 1'b0);
        do_mul("mulh_m3x5",   32'hFFFF_FFFD,  32'd5,          1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        do_mul("mulhu_max",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
        do_mul("mulhsu_m1x2", 32'hFFFF_FFFF,  32'd2,          1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        do_mul("mulh_minmin", 32'h8000_0000,  32'h8000_0000,  1'b1, 1'b1, 64'h4000_0000_0000_0000, 1'b0);
        do_mul("mul_zero",    32'd0,          32'h1234_5678,  1'b1, 1'b1, 64'h0000_0000_0000_0000, 1'b0);

        // Hazard: accept 3x4 at edge 1, ignored 9x9 at edge 10, reset at edge 20.
        @(posedge clock);
        a = 32'd3; b = 32'd4; a_signed = 1'b0; b_signed = 1'b0; start = 1'b1;
        @(negedge clock); #1;
        start = 1'b0;
        for (int e = 2; e <= 9; e++) @(negedge clock);
        @(posedge clock);
        a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clock); #1;
        start = 1'b0;
        check("hz_busy_e10", {63'd0, busy}, 64'd1);
        for (int e = 11; e <= 19; e++) @(negedge clock);
        #1;
        check("hz_partial_e19", {result_high, result_low}, 64'd12);
        check("hz_busy_e19", {63'd0, busy}, 64'd1);
        @(posedge clock);
        reset = 1'b1;
        #1;
        check("hz_reset_out", {result_high, result_low}, 64'd0);
        check("hz_reset_busy", {63'd0, busy}, 64'd0);
        @(negedge clock); #1;
        check("hz_reset_done", {63'd0, done}, 64'd0);
        @(posedge clock);
        reset = 1'b0;
        for (int e = 0; e < 3; e++) begin
            @(negedge clock); #1;
            check("hz_no_done", {62'd0, busy, done}, 64'd0);
        end
        do_mul("hz_2x5", 32'd2, 32'd5, 1'b0, 1'b0, 64'd10, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
